timer: RTL and testbench

TIMER -- requirements
Module: timer

---
 rtl/timer.sv | 71 +++++++
 tb/tb_timer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/timer.sv
// rtl/timer.sv - BCD m:ss countdown timer with shift-in load; TIMER_DIGIT_CLAMP_EN enables digit sanitising.
module timer (
    input  logic       clock,
    input  logic       clearn,
    input  logic [3:0] data,
    input  logic       loadn,
    input  logic       en,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] mins,
    output logic       zero
);

    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] mins_q, mins_d;
    logic [3:0] load_ones;
    logic [3:0] load_tens;
    logic       zero_now;

    assign zero_now = (ones_q == 4'd0) && (tens_q == 4'd0) && (mins_q == 4'd0);

`ifdef TIMER_DIGIT_CLAMP_EN
    assign load_ones = (data > 4'd9)   ? 4'd9 : data;
    assign load_tens = (ones_q > 4'd5) ? 4'd5 : ones_q;
`else
    assign load_ones = data;
    assign load_tens = ones_q;
`endif

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        mins_d = mins_q;
        if (!loadn) begin
            mins_d = tens_q;
            tens_d = load_tens;
            ones_d = load_ones;
        end else if (en && !zero_now) begin
            // Borrow ripples ones -> tens -> minutes; 0:00 is excluded above so mins never underflows.
            if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
            end else if (tens_q != 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
            end else begin
                ones_d = 4'd9;
                tens_d = 4'd5;
                mins_d = mins_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clearn) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
            mins_q <= 4'd0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
            mins_q <= mins_d;
        end
    end

    assign sec_ones = ones_q;
    assign sec_tens = tens_q;
    assign mins     = mins_q;
    assign zero     = zero_now;

endmodule

// File: tb/tb_timer.sv
// tb/tb_timer.sv - Self-checking bench for timer against a seconds-based reference model.
module tb_timer;

    logic       clock;
    logic       clearn;
    logic [3:0] data;
    logic       loadn;
    logic       en;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] mins;
    logic       zero;

    int vectors;
    int miscompares;
    bit model_valid;
    int m_min, m_ten, m_one;

    timer dut (
        .clock    (clock),
        .clearn   (clearn),
        .data     (data),
        .loadn    (loadn),
        .en       (en),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .mins     (mins),
        .zero     (zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: count on the total number of seconds, then split back into digits.
    task automatic model_edge(input bit c, input bit ld_n, input int d, input bit e);
        int total;
        int in_one;
        int in_ten;
        if (c) begin
            m_min = 0; m_ten = 0; m_one = 0;
        end else if (!ld_n) begin
            in_one = d;
            in_ten = m_one;
`ifdef TIMER_DIGIT_CLAMP_EN
            if (in_one > 9) in_one = 9;
            if (in_ten > 5) in_ten = 5;
`endif
            m_min = m_ten;
            m_ten = in_ten;
            m_one = in_one;
        end else if (e) begin
            total = m_min * 60 + m_ten * 10 + m_one;
            if (total > 0) total = total - 1;
            m_min = total / 60;
            m_ten = (total % 60) / 10;
            m_one = total % 10;
        end
    endtask

    task automatic step(input bit c, input bit ld_n, input int d, input bit e);
        clearn = c;
        loadn  = ld_n;
        data   = d[3:0];
        en     = e;
        @(posedge clock);
        model_edge(c, ld_n, d, e);
        model_valid = 1'b1;
        #1;
    endtask

    task automatic check_lit(input string name, input int em, input int et, input int eo, input bit ez);
        vectors++;
        if (mins !== em[3:0] || sec_tens !== et[3:0] || sec_ones !== eo[3:0] || zero !== ez) begin
            miscompares++;
            $display("FAIL %s: got %0d:%0d%0d zero=%0b, expected %0d:%0d%0d zero=%0b",
                     name, mins, sec_tens, sec_ones, zero, em, et, eo, ez);
        end
    endtask

    always @(negedge clock) begin
        if (model_valid) begin
            vectors++;
            if (mins !== m_min[3:0] || sec_tens !== m_ten[3:0] || sec_ones !== m_one[3:0] ||
                zero !== (m_min == 0 && m_ten == 0 && m_one == 0)) begin
                miscompares++;
                $display("FAIL model_cmp @%0t: got %0d:%0d%0d zero=%0b, model %0d:%0d%0d",
                         $time, mins, sec_tens, sec_ones, zero, m_min, m_ten, m_one);
            end
        end
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        model_valid = 1'b0;
        m_min = 0; m_ten = 0; m_one = 0;
        clearn = 1'b1; loadn = 1'b1; en = 1'b0; data = 4'd0;
        @(negedge clock);

        step(1, 0, 9, 1);
        check_lit("reset", 0, 0, 0, 1);

        step(0, 0, 8, 0);
        step(0, 0, 5, 1);
        step(0, 0, 7, 1);
        check_lit("load_857", 8, 5, 7, 0);

        step(0, 1, 0, 1);
        check_lit("count_1", 8, 5, 6, 0);
        for (int i = 0; i < 57; i++) step(0, 1, 0, 1);
        check_lit("count_58", 7, 5, 9, 0);
        for (int i = 0; i < 479; i++) step(0, 1, 0, 1);
        check_lit("count_537", 0, 0, 0, 1);
        for (int i = 0; i < 33; i++) step(0, 1, 0, 1);
        check_lit("hold_at_zero", 0, 0, 0, 1);

        step(0, 0, 1, 0);
        step(0, 0, 2, 0);
        step(0, 0, 3, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
        check_lit("en_low_hold", 1, 2, 3, 0);
        step(0, 0, 4, 1);
        check_lit("load_beats_count", 2, 3, 4, 0);

        step(0, 0, 5, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        check_lit("load_500", 5, 0, 0, 0);
        step(0, 1, 0, 1);
        check_lit("borrow_mins", 4, 5, 9, 0);
        step(1, 1, 0, 1);
        check_lit("clear_mid_count", 0, 0, 0, 1);
        step(0, 1, 0, 1);
        check_lit("after_clear_hold", 0, 0, 0, 1);

        step(0, 0, 6, 0);
        step(1, 0, 3, 0);
        check_lit("clear_mid_load", 0, 0, 0, 1);

        step(0, 0, 4, 0);
        step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        check_lit("borrow_tens", 0, 3, 9, 0);

        step(1, 1, 0, 0);
        step(0, 0, 15, 0);
        step(0, 0, 15, 0);
`ifdef TIMER_DIGIT_CLAMP_EN
        check_lit("clamp_15_15", 0, 5, 9, 0);
`else
        check_lit("raw_15_15", 0, 15, 15, 0);
`endif
        step(1, 1, 0, 0);
        check_lit("final_clear", 0, 0, 0, 1);

        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
